// File: rtl/microsequencer_pkg.sv
// ----------------------------------------------------------------------------
// microsequencer_pkg
//   Shared control-unit definitions: the next-address select encodings driven
//   by the next-state address selector, the condition-select encodings held in
//   the control register, and the default microstore address width.
// ----------------------------------------------------------------------------
package microsequencer_pkg;

   localparam int ADDR_W_DEFAULT = 8;

   // Next-address source select (m1m0)
   typedef enum logic [1:0] {
      SEL_ENC = 2'b00,   // start address from the instruction encoder
      SEL_RST = 2'b01,   // fixed reset/fetch address
      SEL_CR  = 2'b10,   // next-address field of the control register
      SEL_INC = 2'b11    // registered incrementer (sequential flow)
   } addr_sel_e;

   // Condition select for the status bit returned to the selector
   typedef enum logic [1:0] {
      COND_MOC   = 2'b00,   // memory operation complete
      COND_OK    = 2'b01,   // ARM condition-code test result
      COND_FALSE = 2'b10,
      COND_TRUE  = 2'b11
   } cond_sel_e;

endpackage : microsequencer_pkg

// File: rtl/microsequencer_if.sv
// ----------------------------------------------------------------------------
// microsequencer_if
//   Bundle between the control unit (selector, encoder, control register) and
//   the microprogram sequencer.
//   Control side -> sequencer : m1m0, enc_addr, cr_addr, cond_sel, cond_inv,
//                               moc, cond_ok, halt
//   Sequencer -> control side : state, inc_reg, sts, hang
//   Modports: master = control side, slave = sequencer.
// ----------------------------------------------------------------------------
interface microsequencer_if
   import microsequencer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
) ();

   addr_sel_e          m1m0;
   logic [ADDR_W-1:0]  enc_addr;
   logic [ADDR_W-1:0]  cr_addr;
   cond_sel_e          cond_sel;
   logic               cond_inv;
   logic               moc;
   logic               cond_ok;
   logic               halt;

   logic [ADDR_W-1:0]  state;
   logic [ADDR_W-1:0]  inc_reg;
   logic               sts;
   logic               hang;

   modport master (
      output m1m0, enc_addr, cr_addr, cond_sel, cond_inv, moc, cond_ok, halt,
      input  state, inc_reg, sts, hang
   );

   modport slave (
      input  m1m0, enc_addr, cr_addr, cond_sel, cond_inv, moc, cond_ok, halt,
      output state, inc_reg, sts, hang
   );

endinterface : microsequencer_if

// File: rtl/microsequencer_cond_tester.sv
// ----------------------------------------------------------------------------
// microsequencer_cond_tester
//   Combinational condition tester. Picks one condition with i_cond_sel and
//   optionally inverts it to form the status bit fed back to the selector.
//   Ports:
//     i_cond_sel  condition select (COND_MOC/COND_OK/COND_FALSE/COND_TRUE)
//     i_cond_inv  invert the selected condition
//     i_moc       memory operation complete
//     i_cond_ok   ARM condition-code test result
//     o_sts       status bit (selected condition XOR invert)
// ----------------------------------------------------------------------------
module microsequencer_cond_tester
   import microsequencer_pkg::*;
(
   input  cond_sel_e i_cond_sel,
   input  logic      i_cond_inv,
   input  logic      i_moc,
   input  logic      i_cond_ok,
   output logic      o_sts
);

   logic w_cond;

   always_comb begin
      // NOTE: assign a default before the case so no path leaves w_cond
      // unassigned; otherwise synthesis infers a latch.
      w_cond = 1'b0;
      case (i_cond_sel)
         COND_MOC:   w_cond = i_moc;
         COND_OK:    w_cond = i_cond_ok;
         COND_FALSE: w_cond = 1'b0;
         COND_TRUE:  w_cond = 1'b1;
      endcase
   end

   assign o_sts = w_cond ^ i_cond_inv;

endmodule : microsequencer_cond_tester

// File: rtl/microsequencer.sv
// ----------------------------------------------------------------------------
// microsequencer
//   Microprogram sequencer: selects the next microstore address, registers it
//   as the current control state together with its increment, returns the
//   tested status bit to the next-state selector, and flags a stuck self-loop.
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    microsequencer_if.slave (see interface header for signal list)
//   Parameters:
//     ADDR_W      microstore address width
//     RESET_ADDR  address loaded on reset and on select SEL_RST
//     WAIT_LIMIT  consecutive self-loop edges before hang asserts (2..65535)
// ----------------------------------------------------------------------------
module microsequencer
   import microsequencer_pkg::*;
#(
   parameter int                ADDR_W     = ADDR_W_DEFAULT,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
   parameter int                WAIT_LIMIT = 64
) (
   input  logic              clk,
   input  logic              reset,
   microsequencer_if.slave   bus
);

   localparam logic [ADDR_W-1:0] RESET_INC = RESET_ADDR + 1'b1;
   localparam int                WD_CNT_W  = 16;
   // Counter value at which one more self-loop edge sets hang
   localparam logic [WD_CNT_W-1:0] WD_LAST = WD_CNT_W'(WAIT_LIMIT - 1);

   logic [ADDR_W-1:0]   r_state;
   logic [ADDR_W-1:0]   r_inc;
   logic [WD_CNT_W-1:0] r_wd_cnt;
   logic                r_hang;

   logic [ADDR_W-1:0]   w_next;
   logic [ADDR_W-1:0]   w_next_inc;
   logic                w_self_loop;
   logic                w_sts;

   // Next-address mux. SEL_INC takes the registered incrementer, not a fresh
   // r_state + 1, so the selector sees a stable value all cycle.
   always_comb begin
      w_next = r_inc;
      case (bus.m1m0)
         SEL_ENC: w_next = bus.enc_addr;
         SEL_RST: w_next = RESET_ADDR;
         SEL_CR:  w_next = bus.cr_addr;
         SEL_INC: w_next = r_inc;
      endcase
   end

   // Wraps modulo 2^ADDR_W: all-ones rolls over to zero.
   assign w_next_inc  = w_next + 1'b1;
   assign w_self_loop = (w_next == r_state);

   // halt freezes state, incrementer and watchdog together; the watchdog only
   // observes sequencing and never redirects it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= RESET_ADDR;
         r_inc    <= RESET_INC;
         r_wd_cnt <= '0;
         r_hang   <= 1'b0;
      end else if (!bus.halt) begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         r_state <= w_next;
         r_inc   <= w_next_inc;
         if (w_self_loop) begin
            // Counter saturates at WD_LAST; hang is sticky until reset.
            if (r_wd_cnt == WD_LAST) begin
               r_hang <= 1'b1;
            end else begin
               r_wd_cnt <= r_wd_cnt + 1'b1;
            end
         end else begin
            r_wd_cnt <= '0;
         end
      end
   end

   microsequencer_cond_tester u_cond_tester (
      .i_cond_sel (bus.cond_sel),
      .i_cond_inv (bus.cond_inv),
      .i_moc      (bus.moc),
      .i_cond_ok  (bus.cond_ok),
      .o_sts      (w_sts)
   );

   assign bus.state   = r_state;
   assign bus.inc_reg = r_inc;
   assign bus.sts     = w_sts;
   assign bus.hang    = r_hang;

endmodule : microsequencer

// File: tb/tb_microsequencer.sv
// ----------------------------------------------------------------------------
// tb_microsequencer
//   Scenario tasks drive the sequencer through the interface; each pushes its
//   expected state/incrementer/hang onto a scoreboard queue before the clock
//   edge and pops and compares after it.
// ----------------------------------------------------------------------------
module tb_microsequencer;
   import microsequencer_pkg::*;

   localparam int ADDR_W = 8;

   typedef struct {
      string            name;
      logic [ADDR_W-1:0] st;
      logic [ADDR_W-1:0] inc;
      logic             hang;
   } exp_t;

   typedef struct {
      addr_sel_e         sel;
      logic [ADDR_W-1:0] addr;   // driven on both enc_addr and cr_addr
      logic              halt;
      logic [ADDR_W-1:0] st;
      logic [ADDR_W-1:0] inc;
      logic              hang;
   } step_t;

   typedef struct {
      cond_sel_e sel;
      logic      inv;
      logic      moc;
      logic      ok;
      logic      sts;
   } cond_t;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;
   exp_t sb_q[$];
   logic sts_q[$];

   microsequencer_if #(.ADDR_W(ADDR_W)) bus ();

   microsequencer #(
      .ADDR_W     (ADDR_W),
      .RESET_ADDR (8'h00),
      .WAIT_LIMIT (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one step's inputs and record what the registers must hold after
   // the next rising edge.
   task automatic apply_step(input string name, input step_t s);
      bus.m1m0     = s.sel;
      bus.enc_addr = s.addr;
      bus.cr_addr  = s.addr;
      bus.halt     = s.halt;
      sb_q.push_back('{name, s.st, s.inc, s.hang});
   endtask

   task automatic test_reset(input logic pre_hang);
      exp_t e;
      // Move away from the reset address first.
      bus.m1m0    = SEL_CR;
      bus.cr_addr = 8'h77;
      bus.halt    = 1'b0;
      sb_q.push_back('{"pre_reset", 8'h77, 8'h78, pre_hang});
      @(posedge clk); @(negedge clk);
      e = sb_q.pop_front();
      tests_run++;
      if (bus.state !== e.st || bus.inc_reg !== e.inc || bus.hang !== e.hang) begin
         tests_failed++;
         $display("FAIL %s: got state=%h inc=%h hang=%b, want state=%h inc=%h hang=%b",
                  e.name, bus.state, bus.inc_reg, bus.hang, e.st, e.inc, e.hang);
      end
      // Mid-cycle assertion: must take effect with no clock edge.
      reset = 1'b1;
      sb_q.push_back('{"reset_async", 8'h00, 8'h01, 1'b0});
      #1;
      e = sb_q.pop_front();
      tests_run++;
      if (bus.state !== e.st || bus.inc_reg !== e.inc || bus.hang !== e.hang) begin
         tests_failed++;
         $display("FAIL %s: got state=%h inc=%h hang=%b, want state=%h inc=%h hang=%b",
                  e.name, bus.state, bus.inc_reg, bus.hang, e.st, e.inc, e.hang);
      end
      // A pending next under reset is discarded.
      bus.m1m0     = SEL_ENC;
      bus.enc_addr = 8'h33;
      sb_q.push_back('{"reset_held", 8'h00, 8'h01, 1'b0});
      @(posedge clk); @(negedge clk);
      e = sb_q.pop_front();
      tests_run++;
      if (bus.state !== e.st || bus.inc_reg !== e.inc || bus.hang !== e.hang) begin
         tests_failed++;
         $display("FAIL %s: got state=%h inc=%h hang=%b, want state=%h inc=%h hang=%b",
                  e.name, bus.state, bus.inc_reg, bus.hang, e.st, e.inc, e.hang);
      end
      // First edge after release loads next normally.
      reset        = 1'b0;
      bus.enc_addr = 8'h10;
      sb_q.push_back('{"reset_release", 8'h10, 8'h11, 1'b0});
      @(posedge clk); @(negedge clk);
      e = sb_q.pop_front();
      tests_run++;
      if (bus.state !== e.st || bus.inc_reg !== e.inc || bus.hang !== e.hang) begin
         tests_failed++;
         $display("FAIL %s: got state=%h inc=%h hang=%b, want state=%h inc=%h hang=%b",
                  e.name, bus.state, bus.inc_reg, bus.hang, e.st, e.inc, e.hang);
      end
   endtask

   task automatic test_enc_inc();
      step_t tbl [0:2];
      exp_t  e;
      tbl = '{'{SEL_ENC, 8'h2A, 1'b0, 8'h2A, 8'h2B, 1'b0},
              '{SEL_INC, 8'h00, 1'b0, 8'h2B, 8'h2C, 1'b0},
              '{SEL_INC, 8'h00, 1'b0, 8'h2C, 8'h2D, 1'b0}};
      foreach (tbl[i]) begin
         apply_step($sformatf("enc_inc[%0d]", i), tbl[i]);
         @(posedge clk); @(negedge clk);
         e = sb_q.pop_front();
         tests_run++;
         if (bus.state !== e.st || bus.inc_reg !== e.inc || bus.hang !== e.hang) begin
            tests_failed++;
            $display("FAIL %s: got state=%h inc=%h hang=%b, want state=%h inc=%h hang=%b",
                     e.name, bus.state, bus.inc_reg, bus.hang, e.st, e.inc, e.hang);
         end
      end
   endtask

   task automatic test_wrap();
      step_t tbl [0:3];
      exp_t  e;
      tbl = '{'{SEL_CR,  8'hFF, 1'b0, 8'hFF, 8'h00, 1'b0},
              '{SEL_INC, 8'h00, 1'b0, 8'h00, 8'h01, 1'b0},
              '{SEL_INC, 8'h00, 1'b0, 8'h01, 8'h02, 1'b0},
              '{SEL_RST, 8'h5A, 1'b0, 8'h00, 8'h01, 1'b0}};
      foreach (tbl[i]) begin
         apply_step($sformatf("wrap[%0d]", i), tbl[i]);
         @(posedge clk); @(negedge clk);
         e = sb_q.pop_front();
         tests_run++;
         if (bus.state !== e.st || bus.inc_reg !== e.inc || bus.hang !== e.hang) begin
            tests_failed++;
            $display("FAIL %s: got state=%h inc=%h hang=%b, want state=%h inc=%h hang=%b",
                     e.name, bus.state, bus.inc_reg, bus.hang, e.st, e.inc, e.hang);
         end
      end
   endtask

   // Runs under halt so the combinational checks can span a clock edge; the
   // status bit must stay live and the registers must not move.
   task automatic test_cond();
      cond_t tbl [0:9];
      exp_t  e;
      logic  want;
      tbl = '{'{COND_MOC,   1'b1, 1'b0, 1'b0, 1'b1},
              '{COND_MOC,   1'b1, 1'b1, 1'b0, 1'b0},
              '{COND_TRUE,  1'b0, 1'b1, 1'b0, 1'b1},
              '{COND_TRUE,  1'b1, 1'b0, 1'b1, 1'b0},
              '{COND_FALSE, 1'b0, 1'b1, 1'b1, 1'b0},
              '{COND_FALSE, 1'b1, 1'b0, 1'b0, 1'b1},
              '{COND_OK,    1'b0, 1'b0, 1'b1, 1'b1},
              '{COND_OK,    1'b0, 1'b1, 1'b0, 1'b0},
              '{COND_OK,    1'b1, 1'b0, 1'b1, 1'b0},
              '{COND_MOC,   1'b0, 1'b1, 1'b0, 1'b1}};
      bus.halt = 1'b1;
      bus.m1m0 = SEL_INC;
      foreach (tbl[i]) begin
         bus.cond_sel = tbl[i].sel;
         bus.cond_inv = tbl[i].inv;
         bus.moc      = tbl[i].moc;
         bus.cond_ok  = tbl[i].ok;
         sts_q.push_back(tbl[i].sts);
         #1;
         want = sts_q.pop_front();
         tests_run++;
         if (bus.sts !== want) begin
            tests_failed++;
            $display("FAIL cond[%0d]: got sts=%b, want sts=%b", i, bus.sts, want);
         end
      end
      sb_q.push_back('{"cond_halted", 8'h00, 8'h01, 1'b0});
      @(negedge clk);
      e = sb_q.pop_front();
      tests_run++;
      if (bus.state !== e.st || bus.inc_reg !== e.inc || bus.hang !== e.hang) begin
         tests_failed++;
         $display("FAIL %s: got state=%h inc=%h hang=%b, want state=%h inc=%h hang=%b",
                  e.name, bus.state, bus.inc_reg, bus.hang, e.st, e.inc, e.hang);
      end
      bus.halt = 1'b0;
   endtask

   // WAIT_LIMIT = 4: a broken loop must clear the count, then the fourth
   // consecutive self-loop edge sets hang, which survives leaving the loop.
   task automatic test_watchdog();
      step_t tbl [0:11];
      exp_t  e;
      tbl = '{'{SEL_CR,  8'h40, 1'b0, 8'h40, 8'h41, 1'b0},
              '{SEL_CR,  8'h40, 1'b0, 8'h40, 8'h41, 1'b0},
              '{SEL_CR,  8'h40, 1'b0, 8'h40, 8'h41, 1'b0},
              '{SEL_CR,  8'h40, 1'b0, 8'h40, 8'h41, 1'b0},
              '{SEL_CR,  8'h50, 1'b0, 8'h50, 8'h51, 1'b0},
              '{SEL_CR,  8'h50, 1'b0, 8'h50, 8'h51, 1'b0},
              '{SEL_CR,  8'h50, 1'b0, 8'h50, 8'h51, 1'b0},
              '{SEL_CR,  8'h50, 1'b0, 8'h50, 8'h51, 1'b0},
              '{SEL_CR,  8'h50, 1'b0, 8'h50, 8'h51, 1'b1},
              '{SEL_CR,  8'h50, 1'b0, 8'h50, 8'h51, 1'b1},
              '{SEL_CR,  8'h51, 1'b0, 8'h51, 8'h52, 1'b1},
              '{SEL_INC, 8'h00, 1'b0, 8'h52, 8'h53, 1'b1}};
      foreach (tbl[i]) begin
         apply_step($sformatf("watchdog[%0d]", i), tbl[i]);
         @(posedge clk); @(negedge clk);
         e = sb_q.pop_front();
         tests_run++;
         if (bus.state !== e.st || bus.inc_reg !== e.inc || bus.hang !== e.hang) begin
            tests_failed++;
            $display("FAIL %s: got state=%h inc=%h hang=%b, want state=%h inc=%h hang=%b",
                     e.name, bus.state, bus.inc_reg, bus.hang, e.st, e.inc, e.hang);
         end
      end
   endtask

   // Starts at 0x10 with a cleared watchdog. Two self-loops, eight halted
   // edges (five on SEL_INC, three on a self-loop), then two more self-loops:
   // hang may only set on the fourth counted loop.
   task automatic test_halt();
      step_t tbl [0:13];
      exp_t  e;
      tbl = '{'{SEL_CR,  8'h10, 1'b0, 8'h10, 8'h11, 1'b0},
              '{SEL_CR,  8'h10, 1'b0, 8'h10, 8'h11, 1'b0},
              '{SEL_INC, 8'h00, 1'b1, 8'h10, 8'h11, 1'b0},
              '{SEL_INC, 8'h00, 1'b1, 8'h10, 8'h11, 1'b0},
              '{SEL_INC, 8'h00, 1'b1, 8'h10, 8'h11, 1'b0},
              '{SEL_INC, 8'h00, 1'b1, 8'h10, 8'h11, 1'b0},
              '{SEL_INC, 8'h00, 1'b1, 8'h10, 8'h11, 1'b0},
              '{SEL_CR,  8'h10, 1'b1, 8'h10, 8'h11, 1'b0},
              '{SEL_CR,  8'h10, 1'b1, 8'h10, 8'h11, 1'b0},
              '{SEL_CR,  8'h10, 1'b1, 8'h10, 8'h11, 1'b0},
              '{SEL_CR,  8'h10, 1'b0, 8'h10, 8'h11, 1'b0},
              '{SEL_CR,  8'h10, 1'b0, 8'h10, 8'h11, 1'b1},
              '{SEL_INC, 8'h00, 1'b0, 8'h11, 8'h12, 1'b1},
              '{SEL_INC, 8'h00, 1'b0, 8'h12, 8'h13, 1'b1}};
      foreach (tbl[i]) begin
         apply_step($sformatf("halt[%0d]", i), tbl[i]);
         @(posedge clk); @(negedge clk);
         e = sb_q.pop_front();
         tests_run++;
         if (bus.state !== e.st || bus.inc_reg !== e.inc || bus.hang !== e.hang) begin
            tests_failed++;
            $display("FAIL %s: got state=%h inc=%h hang=%b, want state=%h inc=%h hang=%b",
                     e.name, bus.state, bus.inc_reg, bus.hang, e.st, e.inc, e.hang);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      bus.m1m0     = SEL_RST;
      bus.enc_addr = '0;
      bus.cr_addr  = '0;
      bus.cond_sel = COND_TRUE;
      bus.cond_inv = 1'b0;
      bus.moc      = 1'b0;
      bus.cond_ok  = 1'b0;
      bus.halt     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      test_reset(1'b0);
      test_enc_inc();
      test_wrap();
      test_cond();
      test_watchdog();
      test_reset(1'b1);
      test_halt();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: run did not finish, %0d tests run", tests_run);
      $fatal(1, "timeout");
   end

endmodule : tb_microsequencer
